// File: rtl/ihp13_sram_bist_ctrl_if.sv
// ihp13_sram_bist_ctrl_if
// BIST port bundle between the March C- controller and an IHP SG13 single-port SRAM macro.
//   bist_en   -> A_BIST_EN    selects the BIST port of the macro
//   bist_men  -> A_BIST_MEN   memory enable
//   bist_wen  -> A_BIST_WEN   write enable
//   bist_ren  -> A_BIST_REN   read enable
//   bist_addr -> A_BIST_ADDR  word address
//   bist_din  -> A_BIST_DIN   write data
//   bist_bm   -> A_BIST_BM    bit mask
//   dout      <- A_DOUT       read data, one cycle after the read
// master: controller side; slave: macro side.
interface ihp13_sram_bist_ctrl_if #(
   parameter int unsigned AddrWidth = 8,
   parameter int unsigned DataWidth = 64
);
   logic                 bist_en;
   logic                 bist_men;
   logic                 bist_wen;
   logic                 bist_ren;
   logic [AddrWidth-1:0] bist_addr;
   logic [DataWidth-1:0] bist_din;
   logic [DataWidth-1:0] bist_bm;
   logic [DataWidth-1:0] dout;

   modport master (
      output bist_en, bist_men, bist_wen, bist_ren, bist_addr, bist_din, bist_bm,
      input  dout
   );

   modport slave (
      input  bist_en, bist_men, bist_wen, bist_ren, bist_addr, bist_din, bist_bm,
      output dout
   );
endinterface

// File: rtl/ihp13_sram_bist_ctrl.sv
// ihp13_sram_bist_ctrl
// March C- self-test controller for an IHP SG13 single-port SRAM macro. Runs
//   E0 up(w0), E1 up(r0,w1), E2 up(r1,w0), E3 down(r0,w1), E4 down(r1,w0), E5 up(r0)
// with one operation per cycle and checks every read one cycle later.
// Ports:
//   clk_i        clock (also the macro BIST clock)
//   rst_i        synchronous active-high reset
//   start_i      start request, honoured in IDLE or DONE
//   busy_o       test in progress (RUN and DRAIN)
//   done_o       test finished, results valid
//   pass_o       no mismatch seen, only driven in DONE
//   err_cnt_o    saturating mismatch counter
//   fail_addr_o  address of the first mismatch
//   fail_elem_o  March element of the first mismatch
//   bist         macro BIST port (master side)
module ihp13_sram_bist_ctrl #(
   parameter int unsigned NumWords    = 256,
   parameter int unsigned DataWidth   = 64,
   parameter int unsigned AddrWidth   = $clog2(NumWords),
   parameter int unsigned ErrCntWidth = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   pass_o,
   output logic [ErrCntWidth-1:0] err_cnt_o,
   output logic [AddrWidth-1:0]   fail_addr_o,
   output logic [2:0]             fail_elem_o,
   ihp13_sram_bist_ctrl_if.master bist
);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StRun   = 2'd1;
   localparam logic [1:0] StDrain = 2'd2;
   localparam logic [1:0] StDone  = 2'd3;

   localparam logic [AddrWidth-1:0] AddrMax = AddrWidth'(NumWords - 1);

   logic [1:0]             state_q, state_d;
   logic [2:0]             elem_q, elem_d;
   logic [AddrWidth-1:0]   addr_q, addr_d;
   // 0: first (or only) operation of an element at this address, 1: the write of a r/w pair
   logic                   phase_q, phase_d;

   // Read check pipeline: what the read issued last cycle should return
   logic                   chk_vld_q, chk_vld_d;
   logic                   chk_exp_q, chk_exp_d;
   logic [2:0]             chk_elem_q, chk_elem_d;
   logic [AddrWidth-1:0]   chk_addr_q, chk_addr_d;

   logic [ErrCntWidth-1:0] err_cnt_q, err_cnt_d;
   logic [AddrWidth-1:0]   fail_addr_q, fail_addr_d;
   logic [2:0]             fail_elem_q, fail_elem_d;
   logic                   first_fail_q, first_fail_d;

   logic two_op, elem_down, op_write, op_val, addr_last, mismatch, in_run;

   // Current operation decode
   always_comb begin
      two_op    = (elem_q != 3'd0) && (elem_q != 3'd5);
      elem_down = (elem_q == 3'd3) || (elem_q == 3'd4);
      op_write  = (elem_q == 3'd0) || phase_q;
      op_val    = 1'b0;
      if (op_write) begin
         op_val = (elem_q == 3'd1) || (elem_q == 3'd3);  // w1 elements
      end else begin
         op_val = (elem_q == 3'd2) || (elem_q == 3'd4);  // r1 elements
      end
      addr_last = elem_down ? (addr_q == '0) : (addr_q == AddrMax);
   end

   assign mismatch = chk_vld_q && (bist.dout != {DataWidth{chk_exp_q}});

   always_comb begin
      state_d      = state_q;
      elem_d       = elem_q;
      addr_d       = addr_q;
      phase_d      = phase_q;
      chk_vld_d    = 1'b0;
      chk_exp_d    = chk_exp_q;
      chk_elem_d   = chk_elem_q;
      chk_addr_d   = chk_addr_q;
      err_cnt_d    = err_cnt_q;
      fail_addr_d  = fail_addr_q;
      fail_elem_d  = fail_elem_q;
      first_fail_d = first_fail_q;

      case (state_q)
         StIdle, StDone: begin
            if (start_i) begin
               state_d      = StRun;
               elem_d       = 3'd0;
               addr_d       = '0;
               phase_d      = 1'b0;
               err_cnt_d    = '0;
               fail_addr_d  = '0;
               fail_elem_d  = 3'd0;
               first_fail_d = 1'b0;
            end
         end
         StRun: begin
            if (!op_write) begin
               chk_vld_d  = 1'b1;
               chk_exp_d  = op_val;
               chk_elem_d = elem_q;
               chk_addr_d = addr_q;
            end
            if (two_op && !phase_q) begin
               phase_d = 1'b1;
            end else begin
               phase_d = 1'b0;
               if (!addr_last) begin
                  addr_d = elem_down ? addr_q - 1'b1 : addr_q + 1'b1;
               end else if (elem_q == 3'd5) begin
                  state_d = StDrain;
               end else begin
                  elem_d = elem_q + 3'd1;
                  // E3 and E4 run downwards, so they start from the top address
                  addr_d = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? AddrMax : '0;
               end
            end
         end
         StDrain: state_d = StDone;
         default: state_d = StIdle;
      endcase

      // chk_vld_q is only ever set in RUN, so this cannot collide with the clear on start
      if (mismatch) begin
         if (err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + 1'b1;
         end
         if (!first_fail_q) begin
            first_fail_d = 1'b1;
            fail_addr_d  = chk_addr_q;
            fail_elem_d  = chk_elem_q;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= StIdle;
         elem_q       <= 3'd0;
         addr_q       <= '0;
         phase_q      <= 1'b0;
         chk_vld_q    <= 1'b0;
         chk_exp_q    <= 1'b0;
         chk_elem_q   <= 3'd0;
         chk_addr_q   <= '0;
         err_cnt_q    <= '0;
         fail_addr_q  <= '0;
         fail_elem_q  <= 3'd0;
         first_fail_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         elem_q       <= elem_d;
         addr_q       <= addr_d;
         phase_q      <= phase_d;
         chk_vld_q    <= chk_vld_d;
         chk_exp_q    <= chk_exp_d;
         chk_elem_q   <= chk_elem_d;
         chk_addr_q   <= chk_addr_d;
         err_cnt_q    <= err_cnt_d;
         fail_addr_q  <= fail_addr_d;
         fail_elem_q  <= fail_elem_d;
         first_fail_q <= first_fail_d;
      end
   end

   assign in_run      = (state_q == StRun);
   assign busy_o      = in_run || (state_q == StDrain);
   assign done_o      = (state_q == StDone);
   assign pass_o      = done_o && (err_cnt_q == '0);
   assign err_cnt_o   = err_cnt_q;
   assign fail_addr_o = fail_addr_q;
   assign fail_elem_o = fail_elem_q;

   assign bist.bist_en   = busy_o;
   assign bist.bist_men  = in_run;
   assign bist.bist_wen  = in_run && op_write;
   assign bist.bist_ren  = in_run && !op_write;
   assign bist.bist_addr = in_run ? addr_q : '0;
   assign bist.bist_din  = (in_run && op_write) ? {DataWidth{op_val}} : '0;
   assign bist.bist_bm   = in_run ? {DataWidth{1'b1}} : '0;

endmodule

// File: tb/tb_ihp13_sram_bist_ctrl.sv
module tb_ihp13_sram_bist_ctrl;
   localparam int unsigned NumWords    = 256;
   localparam int unsigned DataWidth   = 64;
   localparam int unsigned AddrWidth   = 8;
   localparam int unsigned ErrCntWidth = 16;
   localparam int unsigned NumOps      = 10 * NumWords;

   // March C- as written in the algorithm: per element its direction, op count and
   // ops encoded {is_write, data_bit}, first op in the upper pair
   localparam int         ElNops [6] = '{1, 2, 2, 2, 2, 1};
   localparam bit         ElDown [6] = '{0, 0, 0, 1, 1, 0};
   localparam logic [3:0] ElOps  [6] = '{4'b10_00, 4'b00_11, 4'b01_10,
                                         4'b00_11, 4'b01_10, 4'b00_00};

   logic clk_i = 1'b0;
   logic rst_i;
   logic start_i;
   logic busy_o, done_o, pass_o;
   logic [ErrCntWidth-1:0] err_cnt_o;
   logic [AddrWidth-1:0]   fail_addr_o;
   logic [2:0]             fail_elem_o;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk_i = ~clk_i;

   ihp13_sram_bist_ctrl_if #(.AddrWidth(AddrWidth), .DataWidth(DataWidth)) bist_if ();

   ihp13_sram_bist_ctrl #(
      .NumWords(NumWords),
      .DataWidth(DataWidth),
      .ErrCntWidth(ErrCntWidth)
   ) dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .start_i(start_i),
      .busy_o(busy_o),
      .done_o(done_o),
      .pass_o(pass_o),
      .err_cnt_o(err_cnt_o),
      .fail_addr_o(fail_addr_o),
      .fail_elem_o(fail_elem_o),
      .bist(bist_if)
   );

   // Behavioural macro with an optional stuck-at cell
   logic [DataWidth-1:0] mem [NumWords];
   logic [DataWidth-1:0] dout_q = '0;
   logic                 fault_en = 1'b0;
   logic [AddrWidth-1:0] fault_addr = '0;
   logic [DataWidth-1:0] sa1_mask = '0;
   logic [DataWidth-1:0] sa0_mask = '0;

   function automatic logic [DataWidth-1:0] faulty(input logic [DataWidth-1:0] d,
                                                   input logic [AddrWidth-1:0] a);
      if (fault_en && a == fault_addr) return (d | sa1_mask) & ~sa0_mask;
      return d;
   endfunction

   always @(posedge clk_i) begin
      if (bist_if.bist_men && bist_if.bist_wen)
         mem[bist_if.bist_addr] <= (mem[bist_if.bist_addr] & ~bist_if.bist_bm) |
                                   (bist_if.bist_din & bist_if.bist_bm);
      if (bist_if.bist_men && bist_if.bist_ren)
         dout_q <= faulty(mem[bist_if.bist_addr], bist_if.bist_addr);
   end
   assign bist_if.dout = dout_q;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: run the March algorithm over an array, log ops {wen, ren, addr, din}
   logic [73:0] exp_ops [$];
   logic [73:0] obs_ops [$];
   int          exp_err;
   logic [7:0]  exp_faddr;
   logic [2:0]  exp_felem;

   task automatic model_run();
      logic [DataWidth-1:0] mm [NumWords];
      logic [DataWidth-1:0] v, rd;
      logic [1:0]           op;
      bit                   first;
      int                   a;
      first = 1'b1;
      exp_err = 0;
      exp_faddr = '0;
      exp_felem = '0;
      exp_ops.delete();
      for (int e = 0; e < 6; e++) begin
         for (int i = 0; i < int'(NumWords); i++) begin
            a = ElDown[e] ? int'(NumWords) - 1 - i : i;
            for (int k = 0; k < ElNops[e]; k++) begin
               op = (k == 0) ? ElOps[e][3:2] : ElOps[e][1:0];
               v  = op[0] ? '1 : '0;
               if (op[1]) begin
                  mm[a] = v;
                  exp_ops.push_back({1'b1, 1'b0, 8'(a), v});
               end else begin
                  exp_ops.push_back({1'b0, 1'b1, 8'(a), 64'd0});
                  rd = faulty(mm[a], 8'(a));
                  if (rd !== v) begin
                     if (exp_err < 65535) exp_err++;
                     if (first) begin
                        first = 1'b0;
                        exp_faddr = 8'(a);
                        exp_felem = 3'(e);
                     end
                  end
               end
            end
         end
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".status"}, {busy_o, done_o, pass_o, err_cnt_o, fail_addr_o, fail_elem_o}, '0);
      check({tag, ".ctl"}, {bist_if.bist_en, bist_if.bist_men, bist_if.bist_wen,
                            bist_if.bist_ren, bist_if.bist_addr}, '0);
      check({tag, ".data"}, {bist_if.bist_din, bist_if.bist_bm}, '0);
   endtask

   // One full run from IDLE/DONE; pulse_at>0 pulses start_i on that RUN cycle
   task automatic run_test(input string name, input int pulse_at);
      int cyc;
      int bm_bad;
      int drain_seen;
      int errs_before;
      model_run();
      obs_ops.delete();
      bm_bad = 0;
      drain_seen = 0;
      @(negedge clk_i);
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      check({name, ".entry_clr"}, {err_cnt_o, fail_addr_o, fail_elem_o}, '0);
      check({name, ".entry_flags"}, {busy_o, done_o, pass_o, bist_if.bist_en}, 4'b1001);
      cyc = 0;
      while (busy_o === 1'b1 && cyc <= int'(NumOps) + 4) begin
         if (bist_if.bist_men === 1'b1) begin
            obs_ops.push_back({bist_if.bist_wen, bist_if.bist_ren, bist_if.bist_addr,
                               bist_if.bist_din});
            if (bist_if.bist_bm !== '1) bm_bad++;
         end else if (drain_seen == 0) begin
            drain_seen = 1;
            check({name, ".drain_cycle"}, 128'(cyc), 128'(NumOps));
            check({name, ".drain_en"}, {bist_if.bist_en, bist_if.bist_wen, bist_if.bist_ren},
                  3'b100);
         end
         cyc++;
         start_i = (pulse_at > 0 && cyc == pulse_at);
         @(negedge clk_i);
      end
      start_i = 1'b0;
      check({name, ".busy_cycles"}, 128'(cyc), 128'(NumOps + 1));
      check({name, ".drain_seen"}, 128'(drain_seen), 128'd1);
      check({name, ".bm_ones"}, 128'(bm_bad), 128'd0);
      check({name, ".done_flags"}, {busy_o, done_o, bist_if.bist_en, bist_if.bist_men}, 4'b0100);
      check({name, ".done_bus"}, {bist_if.bist_addr, bist_if.bist_din, bist_if.bist_bm}, '0);
      check({name, ".pass"}, 128'(pass_o), 128'(exp_err == 0));
      check({name, ".err_cnt"}, 128'(err_cnt_o), 128'(exp_err));
      check({name, ".fail_addr"}, 128'(fail_addr_o), 128'(exp_faddr));
      check({name, ".fail_elem"}, 128'(fail_elem_o), 128'(exp_felem));
      check({name, ".op_count"}, 128'(obs_ops.size()), 128'(exp_ops.size()));
      for (int i = 0; i < exp_ops.size() && i < obs_ops.size(); i++) begin
         errs_before = n_errors;
         check($sformatf("%s.op%0d", name, i), 128'(obs_ops[i]), 128'(exp_ops[i]));
         if (n_errors != errs_before) break;
      end
      repeat (3) @(negedge clk_i);
      check({name, ".hold"}, {done_o, err_cnt_o, fail_addr_o}, {1'b1, 16'(exp_err), exp_faddr});
   endtask

   initial begin
      rst_i = 1'b1;
      start_i = 1'b0;
      repeat (3) @(negedge clk_i);
      check_all_zero("reset");
      rst_i = 1'b0;

      // start and reset together: reset wins
      @(negedge clk_i);
      start_i = 1'b1;
      rst_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      rst_i = 1'b0;
      check_all_zero("start_rst");

      run_test("clean", 0);

      fault_en = 1'b1;
      fault_addr = 8'h2A;
      sa1_mask = 64'h20;
      sa0_mask = '0;
      run_test("sa1_2a", 0);
      check("sa1_2a.spec", {pass_o, err_cnt_o, fail_addr_o, fail_elem_o},
            {1'b0, 16'd3, 8'h2A, 3'd1});

      // restart from DONE with a prior failure on a clean macro
      fault_en = 1'b0;
      run_test("restart", 0);

      fault_en = 1'b1;
      fault_addr = 8'hFF;
      sa1_mask = '0;
      sa0_mask = '1;
      run_test("sa0_ff", 0);
      check("sa0_ff.spec", {pass_o, err_cnt_o, fail_addr_o, fail_elem_o},
            {1'b0, 16'd2, 8'hFF, 3'd2});

      for (int t = 0; t < 3; t++) begin
         fault_addr = 8'($urandom_range(0, NumWords - 1));
         sa1_mask = '0;
         sa0_mask = '0;
         if ($urandom_range(0, 1) == 1) sa1_mask[$urandom_range(0, DataWidth - 1)] = 1'b1;
         else sa0_mask[$urandom_range(0, DataWidth - 1)] = 1'b1;
         run_test($sformatf("rand%0d", t), 0);
      end

      fault_en = 1'b0;
      run_test("mid_start", int'($urandom_range(100, 2400)));

      // reset at RUN cycle 700 with a fault already recorded
      fault_en = 1'b1;
      fault_addr = 8'h2A;
      sa1_mask = 64'h20;
      sa0_mask = '0;
      @(negedge clk_i);
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      repeat (699) @(negedge clk_i);
      check("pre_rst.err", {busy_o, err_cnt_o, fail_addr_o}, {1'b1, 16'd1, 8'h2A});
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      check_all_zero("mid_rst");

      fault_en = 1'b0;
      run_test("after_rst", 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/ihp13_sram_bist_ctrl.md
# ihp13_sram_bist_ctrl

March C- built-in self-test controller for the IHP SG13 single-port SRAM macros (`RM_IHPSG13_1P_*_c2_bm_bist`). It is the initiator side of the macro BIST port: it drives `A_BIST_*`, which the functional SRAM wrapper otherwise ties to zero, and checks `A_DOUT`. One instance sits beside each macro or macro group. The SoC test register block starts it and reads back pass/fail.

## Interface
Parameters:
- `NumWords`, 256: words in the macro under test (256 or 1024); power of two, ≥ 2
- `DataWidth`, 64: macro word width
- `AddrWidth`, `$clog2(NumWords)`: derived, do not override
- `ErrCntWidth`, 16: width of the saturating mismatch counter

Ports:
- `clk_i`  in  1  clock; also feeds the macro `A_BIST_CLK`
- `rst_i`  in  1  reset; one clock; synchronous, active-high
- `start_i`  in  1  start request, sampled in IDLE or DONE
- `busy_o`  out  1  test in progress
- `done_o`  out  1  test finished; level, results valid
- `pass_o`  out  1  no mismatch seen; valid when `done_o`
- `err_cnt_o`  out  ErrCntWidth  mismatch count, saturates at all-ones
- `fail_addr_o`  out  AddrWidth  address of first mismatch
- `fail_elem_o`  out  3  March element (0–5) of first mismatch
- `bist_en_o`  out  1  to `A_BIST_EN`; selects the BIST port
- `bist_men_o`  out  1  to `A_BIST_MEN`
- `bist_wen_o`  out  1  to `A_BIST_WEN`
- `bist_ren_o`  out  1  to `A_BIST_REN`
- `bist_addr_o`  out  AddrWidth  to `A_BIST_ADDR`
- `bist_din_o`  out  DataWidth  to `A_BIST_DIN`
- `bist_bm_o`  out  DataWidth  to `A_BIST_BM`
- `dout_i`  in  DataWidth  from `A_DOUT`; read data one cycle after the read

## Operation
- States:
  - IDLE → RUN on `start_i`.
  - RUN → DRAIN after the last operation.
  - DRAIN → DONE.
  - DONE → RUN on `start_i`.
- Reset: state IDLE. Every output is 0, including `pass_o`, `err_cnt_o`, `fail_addr_o` and `fail_elem_o`.
- Entering RUN clears `err_cnt_o`, `fail_*_o` and the first-fail flag.
- March C- elements, with D0 = all-zeros and D1 = all-ones:
  - E0 ⇑(w0)
  - E1 ⇑(r0,w1)
  - E2 ⇑(r1,w0)
  - E3 ⇓(r0,w1)
  - E4 ⇓(r1,w0)
  - E5 ⇑(r0)
- Up elements count the address 0 → NumWords-1; down elements count NumWords-1 → 0. The address counter reloads at each element boundary.
- Two-operation elements issue the read then the write to the same address on consecutive cycles. Single-operation elements issue one operation per cycle.
- One operation per cycle, no idle cycles between elements. Total operations: 10·NumWords.
- Operation cycle:
  - `bist_men_o`=1; `bist_bm_o`=all-ones.
  - Write: `bist_wen_o`=1, `bist_ren_o`=0, `bist_din_o`=D0 or D1.
  - Read: `bist_wen_o`=0, `bist_ren_o`=1, `bist_din_o`=0.
- Read check pipeline: a read registers the expected value, element and address. On the next cycle `dout_i` is compared against the expected value.
- On mismatch:
  - `err_cnt_o` increments, saturating.
  - On the first mismatch only, `fail_addr_o` and `fail_elem_o` latch and the first-fail flag sets.
- The test never aborts on a mismatch.
- `pass_o` = (err_cnt == 0) and is driven only in DONE; it is 0 elsewhere.
- `start_i` in RUN or DRAIN is ignored.

## Timing
- Cycle 0: `start_i`=1 in IDLE/DONE. `busy_o`, `bist_en_o` and `bist_men_o` rise at cycle 1, where the first operation is E0 w0 @ address 0.
- Cycles 1…10·NumWords: RUN. `bist_men_o` is high on every one of these cycles.
- Cycle 10·NumWords+1: DRAIN.
  - `bist_men_o`=0; `bist_en_o`=1; `busy_o`=1.
  - The last E5 read is compared.
- Cycle 10·NumWords+2: DONE.
  - `busy_o`=0, `bist_en_o`=0, `done_o`=1.
  - Results are stable until the next start or reset.
- `busy_o` is high for exactly 10·NumWords+1 cycles.
- Outside RUN, all `bist_*_o` outputs are 0, except `bist_en_o` in DRAIN.
- `rst_i` mid-RUN: on the next edge all outputs return to 0 and the state is IDLE. No partial results are retained.
- `start_i` held high in DONE restarts immediately, and the results clear at the RUN entry edge.
- `start_i` and `rst_i` asserted together: reset wins.

## Test plan
- Fault-free behavioural macro model, NumWords=256. Pulse `start_i` → `busy_o` high for 2561 cycles, then `done_o`=1, `pass_o`=1, `err_cnt_o`=0.
- Sequence check, NumWords=4. Log the operations → exact order:
  - w0@0–3
  - (r0,w1)@0–3
  - (r1,w0)@0–3
  - (r0,w1)@3–0
  - (r1,w0)@3–0
  - r0@0–3

  That is 40 operations, with `bist_bm_o`=all-ones throughout.
- Stuck-at-1 on bit 5 of address 0x2A, NumWords=256:
  - `pass_o`=0, `fail_addr_o`=0x2A, `fail_elem_o`=1.
  - `err_cnt_o`=3 (failing reads in E1, E3 and E5).
- Stuck-at-0 on all bits of address 0xFF:
  - `fail_addr_o`=0xFF, `fail_elem_o`=2.
  - `err_cnt_o`=2 (failing reads in E2 and E4).
- Assert `rst_i` at RUN cycle 700 → all outputs 0 next cycle. A fresh start then gives `done_o` after 2561 busy cycles.
- Restart from DONE with a prior failure, using the fault-free model → `err_cnt_o` and `fail_*_o` clear at RUN entry, and the run ends with `pass_o`=1.
- `start_i` pulsed mid-RUN → ignored; the cycle count is unchanged.
